// File: rtl/channel_util_pkg.sv
// channel_util_pkg: shared FSM state type and flit-count helper for channel width converters
package channel_util_pkg;
  typedef enum logic {SER_IDLE, SER_SEND} ser_state_t;
  function automatic int flits_per_word(int nin, int nout);
    return (nin + nout - 1) / nout;
  endfunction
endpackage

// File: rtl/channel_if.sv
// channel_if: valid/ack channel (d, v from master; a from slave)
interface channel_if #(parameter int W = 8);
  logic [W-1:0] d;
  logic v;
  logic a;
  modport master(output d, v, input a);
  modport slave(input d, v, output a);
endinterface

// File: rtl/flit_select.sv
// flit_select: picks flit idx of word, LSB slice first, zero-padding bits beyond NIn
module flit_select #(
  parameter int NIn = 20,
  parameter int NOut = 8,
  parameter int K = 3,
  localparam int IW = $clog2(K + 1)
) (
  input  logic [NIn-1:0]  word,
  input  logic [IW-1:0]   idx,
  output logic [NOut-1:0] flit
);
  logic [K*NOut-1:0] padded;
  assign padded = (K*NOut)'(word);
  assign flit = padded[idx*NOut +: NOut];
endmodule

// File: rtl/channel_serializer.sv
// channel_serializer: splits each NIn-bit word on in into K NOut-bit flits on out, registered, full throughput
module channel_serializer
  import channel_util_pkg::*;
#(
  parameter int NIn = 20,
  parameter int NOut = 8
) (
  input logic clk,
  input logic reset,
  channel_if.slave in,
  channel_if.master out
);
  localparam int K = flits_per_word(NIn, NOut);
  localparam int IW = $clog2(K + 1);
  ser_state_t state, state_n;
  logic [NIn-1:0] word;
  logic [IW-1:0] idx;
  logic [NOut-1:0] flit;
  logic send, last, take;
  flit_select #(.NIn(NIn), .NOut(NOut), .K(K)) u_sel (.word(word), .idx(idx), .flit(flit));
  assign send = state == SER_SEND;
  assign last = idx == IW'(K - 1);
  // a new word is taken when idle, or alongside the final flit for a zero-bubble handoff
  always_comb begin
    take = ~reset & in.v & (~send | (last & out.a));
    in.a = take;
    out.v = send;
    out.d = send ? flit : '0;
    state_n = take ? SER_SEND : (send & out.a & last) ? SER_IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SER_IDLE;
      word <= '0;
      idx <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        word <= in.d;
        idx <= '0;
      end else if (send & out.a & ~last) idx <= idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_channel_serializer.sv
// tb_channel_serializer: directed + model-checked bench for 20->8 and 8->8 serializers
module tb_channel_serializer;
  logic clk, reset, started;
  int tests, fails;
  int b_acc, b_del;
  logic [7:0] a_q[$], b_q[$], a_log[$];
  channel_if #(20) a_in();
  channel_if #(8) a_out();
  channel_if #(8) b_in();
  channel_if #(8) b_out();
  channel_serializer #(.NIn(20), .NOut(8)) dut_a (.clk(clk), .reset(reset), .in(a_in), .out(a_out));
  channel_serializer #(.NIn(8), .NOut(8)) dut_b (.clk(clk), .reset(reset), .in(b_in), .out(b_out));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_log(input string nm, input logic [7:0] e[$]);
    chk({nm, "_len"}, a_log.size(), e.size());
    for (int i = 0; i < e.size() && i < a_log.size(); i++) chk(nm, a_log[i], e[i]);
  endtask
  // reference model: a queue of flits still owed downstream; a word is accepted exactly
  // when the queue would be empty by the end of this cycle
  always @(negedge clk) begin
    if (started) begin
      logic ea, eb;
      chk("a_outv", a_out.v, a_q.size() != 0);
      chk("a_outd", a_out.d, a_q.size() != 0 ? a_q[0] : 8'h00);
      ea = !reset && a_in.v && (a_q.size() == 0 || (a_q.size() == 1 && a_out.a));
      chk("a_ina", a_in.a, ea);
      chk("b_outv", b_out.v, b_q.size() != 0);
      chk("b_outd", b_out.d, b_q.size() != 0 ? b_q[0] : 8'h00);
      eb = !reset && b_in.v && (b_q.size() == 0 || (b_q.size() == 1 && b_out.a));
      chk("b_ina", b_in.a, eb);
      if (reset) begin
        a_q.delete();
        b_q.delete();
      end else begin
        if (a_q.size() != 0 && a_out.a) begin
          a_log.push_back(a_q[0]);
          void'(a_q.pop_front());
        end
        if (b_q.size() != 0 && b_out.a) begin
          b_del++;
          void'(b_q.pop_front());
        end
        if (ea) for (int i = 0; i < 3; i++) a_q.push_back(8'((a_in.d >> (8 * i)) & 20'hFF));
        if (eb) begin
          b_acc++;
          b_q.push_back(b_in.d);
        end
      end
    end
  end
  initial begin
    tests = 0; fails = 0; b_acc = 0; b_del = 0; started = 0;
    reset = 1;
    a_in.v = 1; a_in.d = 20'hABCDE; a_out.a = 1;
    b_in.v = 0; b_in.d = 0; b_out.a = 0;
    repeat (3) begin
      @(posedge clk);
      started = 1;
      @(negedge clk);
      chk("rst_ina", a_in.a, 0);
      chk("rst_outv", a_out.v, 0);
      chk("rst_outd", a_out.d, 0);
    end
    step(); reset = 0;
    @(negedge clk);
    chk("post_rst_ina", a_in.a, 1);
    step(); a_in.v = 0;
    @(negedge clk);
    chk("basic_flit0", a_out.d, 8'hDE);
    repeat (4) step();
    check_log("basic", '{8'hDE, 8'hBC, 8'h0A});
    a_log.delete();
    a_in.v = 1; a_in.d = 20'hABCDE; a_out.a = 1;
    step(); a_in.d = 20'h55555;
    step(); a_out.a = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_outd", a_out.d, 8'hBC);
      chk("bp_outv", a_out.v, 1);
      chk("bp_ina", a_in.a, 0);
      if (i < 3) step();
    end
    step(); a_out.a = 1;
    step();
    @(negedge clk);
    chk("bp_handoff_ina", a_in.a, 1);
    step(); a_in.v = 0;
    repeat (4) step();
    check_log("bp", '{8'hDE, 8'hBC, 8'h0A, 8'h55, 8'h55, 8'h05});
    a_log.delete();
    a_in.v = 1; a_in.d = 20'h12345;
    step(); a_in.d = 20'h6789A;
    step();
    step();
    @(negedge clk);
    chk("b2b_ina", a_in.a, 1);
    chk("b2b_flit", a_out.d, 8'h01);
    step(); a_in.v = 0;
    repeat (4) step();
    check_log("b2b", '{8'h45, 8'h23, 8'h01, 8'h9A, 8'h78, 8'h06});
    a_log.delete();
    a_in.v = 1; a_in.d = 20'hFFFFF;
    step(); a_in.v = 0;
    step(); reset = 1;
    step(); reset = 0;
    @(negedge clk);
    chk("midrst_outv", a_out.v, 0);
    step(); a_in.v = 1; a_in.d = 20'h0ABCD;
    step(); a_in.v = 0;
    repeat (4) step();
    check_log("midrst", '{8'hFF, 8'h CD, 8'hAB, 8'h00});
    for (int i = 0; i < 300; i++) begin
      step();
      b_in.v = 1'($urandom_range(0, 1));
      b_in.d = 8'($urandom);
      b_out.a = $urandom_range(0, 3) != 0;
    end
    step(); b_in.v = 0; b_out.a = 1;
    repeat (3) step();
    chk("k1_nonempty", b_acc > 20, 1);
    chk("k1_no_loss", b_del, b_acc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
